cmp_share_arb: RTL and testbench

CMP_SHARE_ARB -- requirements
Module: cmp_share_arb

---
 rtl/cmp_share_arb_pkg.sv | 14 +
 rtl/cmp_share_arb_compm10.sv | 14 +
 rtl/cmp_share_arb.sv | 127 ++++++++++++
 tb/tb_cmp_share_arb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_share_arb_pkg.sv
// Shared constants and FSM encoding for the shared-comparator arbiter.
package cmp_share_arb_pkg;

  localparam int CMP_W    = 10;
  localparam int CMP_NREQ = 4;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_share_arb_compm10.sv
// 10-bit unsigned magnitude comparator, purely combinational.
import cmp_share_arb_pkg::*;

module compm10 (
  input  logic [CMP_W-1:0] a,
  input  logic [CMP_W-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one compm10 among four requesters.
// Grant in cycle t, result valid from t+2 and held until RES_READY.
import cmp_share_arb_pkg::*;

module cmp_share_arb #(
  parameter int W    = CMP_W,
  parameter int NREQ = CMP_NREQ
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [W*NREQ-1:0] A_IN,
  input  logic [W*NREQ-1:0] B_IN,
  output logic [NREQ-1:0]   GNT,
  output logic              BUSY,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [1:0]        RES_ID,
  output logic              RES_GT,
  output logic              RES_LT,
  output logic              RES_EQ,
  output logic [CNT_W-1:0]  CNT
);

  // Returns {found, index}; the search starts at ptr and wraps around.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  state_t           state_q;
  state_t           state_nxt;
  logic [1:0]       ptr_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [1:0]       id_q;
  logic [1:0]       res_id_q;
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       pick;
  logic             win_vld;
  logic [1:0]       win_id;
  logic             grant;
  logic             cmp_gt;
  logic             cmp_lt;

  assign pick    = rr_pick(REQ, ptr_q);
  assign win_vld = pick[2];
  assign win_id  = pick[1:0];
  assign grant   = |GNT;

  compm10 u_cmp (
    .a  (a_q),
    .b  (b_q),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: if (win_vld)   state_nxt = ST_CMP;
      ST_CMP:                 state_nxt = ST_RESP;
      ST_RESP: if (RES_READY) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Grant is masked by RST so a reset cycle never marks a capture.
  always_comb begin
    GNT = '0;
    if (state_q == ST_IDLE && win_vld && !RST) GNT[win_id] = 1'b1;
    BUSY      = (state_q != ST_IDLE);
    RES_VALID = (state_q == ST_RESP);
  end

  assign cnt_nxt = (state_q == ST_RESP && RES_READY && cnt_q != '1) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q    <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 2'd0;
      res_id_q <= 2'd0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (grant) begin
        ptr_q <= win_id + 2'd1;
        a_q   <= A_IN[win_id*W +: W];
        b_q   <= B_IN[win_id*W +: W];
        id_q  <= win_id;
      end
      if (state_q == ST_CMP) begin
        res_id_q <= id_q;
        gt_q     <= cmp_gt;
        lt_q     <= cmp_lt;
        eq_q     <= ~cmp_gt & ~cmp_lt;
      end
      cnt_q <= cnt_nxt;
    end
  end

  assign RES_ID = res_id_q;
  assign RES_GT = gt_q;
  assign RES_LT = lt_q;
  assign RES_EQ = eq_q;
  assign CNT    = cnt_q;

endmodule

// File: tb/tb_cmp_share_arb.sv
// Bench for cmp_share_arb: transaction-level model checked every cycle plus directed sequences.
module tb_cmp_share_arb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RES_READY;
  logic [3:0]  REQ;
  logic [39:0] A_IN;
  logic [39:0] B_IN;
  logic [3:0]  GNT;
  logic        BUSY;
  logic        RES_VALID;
  logic [1:0]  RES_ID;
  logic        RES_GT;
  logic        RES_LT;
  logic        RES_EQ;
  logic [15:0] CNT;

  always #5 CLK = ~CLK;

  cmp_share_arb #(.W(10), .NREQ(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
    .GNT(GNT), .BUSY(BUSY), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_ID(RES_ID), .RES_GT(RES_GT), .RES_LT(RES_LT), .RES_EQ(RES_EQ), .CNT(CNT)
  );

  int errors = 0;
  int checks = 0;

  // Model: one transaction at a time; age 0 = comparing, age 1 = result offered.
  bit         m_busy;
  int         m_age;
  int         m_id;
  int         m_a;
  int         m_b;
  int         m_last;
  logic [1:0] m_res_id;
  logic [2:0] m_res;
  int         m_cnt;

  logic [3:0]  s_gnt;
  logic        s_valid;
  logic [1:0]  s_id;
  logic [2:0]  s_res;
  logic [15:0] s_cnt;
  int          gnt_log[$];

  typedef struct {
    int         a;
    int         b;
    int         idx;
    logic [2:0] res;
  } vec_t;
  vec_t tv[8];
  int   rr_exp[5] = '{0, 1, 2, 3, 0};

  function automatic logic [39:0] rand40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_id = 0; m_last = 3;
    m_res_id = 2'd0; m_res = 3'b000; m_cnt = 0;
  endtask

  task automatic cycle();
    int w;
    logic [3:0] e_gnt;
    @(negedge CLK);
    w = -1;
    if (!m_busy && !RST)
      for (int k = 1; k <= 4; k++)
        if (w < 0 && REQ[(m_last + k) % 4]) w = (m_last + k) % 4;
    e_gnt = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    s_gnt = GNT; s_valid = RES_VALID; s_id = RES_ID;
    s_res = {RES_GT, RES_LT, RES_EQ}; s_cnt = CNT;
    chk("cycle", {5'b0, GNT, BUSY, RES_VALID, RES_ID, RES_GT, RES_LT, RES_EQ, CNT},
                 {5'b0, e_gnt, m_busy, (m_busy && m_age == 1), m_res_id, m_res, m_cnt[15:0]});
    for (int i = 0; i < 4; i++) if (GNT[i]) gnt_log.push_back(i);
    if (RST) model_reset();
    else if (m_busy) begin
      if (m_age == 0) begin
        m_res = {m_a > m_b, m_a < m_b, m_a == m_b};
        m_res_id = 2'(m_id);
        m_age = 1;
      end else if (RES_READY) begin
        m_busy = 0;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (w >= 0) begin
      m_busy = 1; m_age = 0; m_id = w; m_last = w;
      m_a = int'(A_IN[w*10 +: 10]);
      m_b = int'(B_IN[w*10 +: 10]);
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    RST = 0; REQ = 4'b0000; RES_READY = 1;
    repeat (n) cycle();
  endtask

  initial begin
    logic [15:0] cnt_before;
    tv[0] = '{700, 300, 0, 3'b100};
    tv[1] = '{5, 6, 0, 3'b010};
    tv[2] = '{1023, 1023, 2, 3'b001};
    tv[3] = '{0, 0, 3, 3'b001};
    tv[4] = '{0, 1023, 1, 3'b010};
    tv[5] = '{1023, 0, 1, 3'b100};
    tv[6] = '{512, 511, 2, 3'b100};
    tv[7] = '{511, 512, 3, 3'b010};

    RST = 1; REQ = 4'b0000; A_IN = '0; B_IN = '0; RES_READY = 1;
    model_reset();
    @(posedge CLK); #1;
    REQ = 4'b1111;
    cycle();
    chk("reset_state", {5'b0, GNT, BUSY, RES_VALID, RES_ID, RES_GT, RES_LT, RES_EQ, CNT}, 32'h0);
    RST = 0; REQ = 4'b0000;

    // Single-requester vectors; A is overwritten with 900 right after capture.
    for (int i = 0; i < 8; i++) begin
      REQ = 4'b0001 << tv[i].idx;
      A_IN = rand40(); B_IN = rand40();
      A_IN[tv[i].idx*10 +: 10] = 10'(tv[i].a);
      B_IN[tv[i].idx*10 +: 10] = 10'(tv[i].b);
      cycle();
      chk("tbl_gnt", 32'(s_gnt), 32'(4'b0001 << tv[i].idx));
      REQ = 4'b0000; A_IN = {4{10'd900}}; B_IN = rand40();
      cycle();
      chk("tbl_early", 32'(s_valid), 32'd0);
      cycle();
      chk("tbl_valid", 32'(s_valid), 32'd1);
      chk("tbl_id", 32'(s_id), 32'(tv[i].idx));
      chk("tbl_res", 32'(s_res), 32'(tv[i].res));
      cycle();
      chk("tbl_cnt", 32'(s_cnt), 32'(i + 1));
    end

    // All four requesting: rotation 0,1,2,3,0.
    RST = 1; cycle(); RST = 0;
    gnt_log.delete();
    REQ = 4'b1111;
    repeat (15) begin A_IN = rand40(); B_IN = rand40(); cycle(); end
    chk("rr_len", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, 32'(rr_exp[i]));

    // Backpressure with equal operands and competing requests.
    idle(4);
    REQ = 4'b0100; A_IN = rand40(); B_IN = rand40();
    A_IN[29:20] = 10'd1023; B_IN[29:20] = 10'd1023; RES_READY = 0;
    cycle();
    chk("bp_gnt", 32'(s_gnt), 32'h4);
    REQ = 4'b1111;
    cycle();
    cnt_before = s_cnt;
    repeat (5) begin
      cycle();
      chk("bp_hold", {24'b0, s_valid, s_res, s_gnt}, {24'b0, 1'b1, 3'b001, 4'b0000});
    end
    RES_READY = 1;
    cycle();
    chk("bp_accept", 32'(s_valid), 32'd1);
    REQ = 4'b0000;
    cycle();
    chk("bp_cnt", 32'(s_cnt), 32'(cnt_before + 16'd1));

    // Reset while comparing aborts the transaction.
    idle(3);
    RST = 1; cycle(); RST = 0;
    REQ = 4'b0001; A_IN[9:0] = 10'd5; B_IN[9:0] = 10'd6;
    cycle();
    chk("abort_gnt", 32'(s_gnt), 32'h1);
    REQ = 4'b0000; RST = 1;
    cycle();
    RST = 0;
    repeat (3) begin
      cycle();
      chk("abort_quiet", {15'b0, s_valid, s_cnt}, 32'h0);
    end
    REQ = 4'b1000;
    cycle();
    chk("after_abort_gnt", 32'(s_gnt), 32'h8);
    idle(3);
    RST = 1; cycle(); RST = 0;
    REQ = 4'b1001;
    cycle();
    chk("prio0_gnt", 32'(s_gnt), 32'h1);
    idle(4);

    // Random traffic with occasional reset, checked by the model every cycle.
    repeat (400) begin
      RST = ($urandom_range(0, 99) == 0);
      REQ = 4'($urandom);
      A_IN = rand40(); B_IN = rand40();
      if ($urandom_range(0, 3) == 0) B_IN = A_IN;
      RES_READY = ($urandom_range(0, 9) < 7);
      cycle();
    end

    // Counter saturation, preloaded just below the ceiling.
    idle(4);
    force dut.cnt_q = 16'hFFFD;
    m_cnt = 65533;
    @(posedge CLK); #1;
    release dut.cnt_q;
    REQ = 4'b0001; RES_READY = 1;
    repeat (12) begin A_IN = rand40(); B_IN = rand40(); cycle(); end
    REQ = 4'b0000;
    cycle();
    chk("sat", 32'(s_cnt), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
